// File: rtl/apb_spi_master.sv
// apb_spi_master: APB registers, TX/RX FIFOs and a mode-0 MSB-first SPI master.
// Define SPI_LOOPBACK_EN to build the CTRL.LOOP internal MOSI->MISO path.
module apb_spi_master #(
   parameter int AWIDTH     = 4,
   parameter int DWIDTH     = 8,
   parameter int FIFO_DEPTH = 5,
   parameter int CLK_DIV    = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [AWIDTH-1:0] PADDR,
   input  logic [DWIDTH-1:0] PWDATA,
   output logic [DWIDTH-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              SPI_SCLK,
   output logic              SPI_CS_N,
   output logic              SPI_MOSI,
   input  logic              SPI_MISO
);
   localparam int N  = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DWIDTH + 1);

   localparam logic [AWIDTH-1:0] A_CTRL = AWIDTH'(0);
   localparam logic [AWIDTH-1:0] A_STAT = AWIDTH'(1);
   localparam logic [AWIDTH-1:0] A_TXD  = AWIDTH'(2);
   localparam logic [AWIDTH-1:0] A_RXD  = AWIDTH'(3);
   localparam logic [AWIDTH-1:0] A_DIV  = AWIDTH'(4);
   localparam logic [AWIDTH-1:0] A_TXL  = AWIDTH'(5);
   localparam logic [AWIDTH-1:0] A_RXL  = AWIDTH'(6);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD
   } state_t;

   state_t              r_state, w_nstate;
   logic                r_en;
   logic [DWIDTH-1:0]   r_div, r_div_lat, r_cnt;
   logic [DWIDTH-1:0]   r_shreg;
   logic [BW-1:0]       r_bits;
   logic                r_sclk, r_csn, r_rxbit;

   logic [DWIDTH-1:0]   r_tx_mem [FIFO_DEPTH];
   logic [DWIDTH-1:0]   r_rx_mem [FIFO_DEPTH];
   logic [PW-1:0]       r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [N-1:0]        r_tx_cnt, r_rx_cnt;

   logic                w_acc, w_err, w_flush, w_loop, w_miso, w_mosi;
   logic                w_push_tx, w_pop_rx, w_wr_ctrl, w_wr_div;
   logic                w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic                w_tick, w_pop_tx, w_rise, w_fall, w_push_rx;
   logic                w_busy;
   logic [DWIDTH-1:0]   w_rdata, w_rx_word;
   logic [PW-1:0]       w_rx_widx;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_acc      = PSEL & PENABLE;
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == N'(FIFO_DEPTH));
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == N'(FIFO_DEPTH));
   assign w_busy     = (r_state != S_IDLE);

   // Error judged on pre-edge FIFO levels; engine activity never changes it.
   always_comb begin
      w_err = 1'b0;
      if (w_acc) begin
         if (PADDR > A_RXL)
            w_err = 1'b1;
         else if (PWRITE)
            w_err = (PADDR == A_STAT) | (PADDR == A_RXD) |
                    (PADDR == A_TXL)  | (PADDR == A_RXL) |
                    ((PADDR == A_TXD) & w_tx_full);
         else
            w_err = (PADDR == A_TXD) |
                    ((PADDR == A_RXD) & w_rx_empty);
      end
   end

   assign w_push_tx = w_acc & PWRITE & ~w_err & (PADDR == A_TXD);
   assign w_pop_rx  = w_acc & ~PWRITE & ~w_err & (PADDR == A_RXD);
   assign w_wr_ctrl = w_acc & PWRITE & ~w_err & (PADDR == A_CTRL);
   assign w_wr_div  = w_acc & PWRITE & ~w_err & (PADDR == A_DIV);
   assign w_flush   = w_wr_ctrl & PWDATA[3];

   always_comb begin
      w_rdata = '0;
      if (w_acc && !PWRITE && !w_err) begin
         case (PADDR)
            A_CTRL:  w_rdata = DWIDTH'({w_loop, 1'b0, r_en});
            A_STAT:  w_rdata = DWIDTH'({w_busy, w_rx_full, w_rx_empty,
                                        w_tx_full, w_tx_empty});
            A_RXD:   w_rdata = r_rx_mem[r_rx_rp];
            A_DIV:   w_rdata = r_div;
            A_TXL:   w_rdata = DWIDTH'(r_tx_cnt);
            A_RXL:   w_rdata = DWIDTH'(r_rx_cnt);
            default: w_rdata = '0;
         endcase
      end
   end

   assign PRDATA  = w_rdata;
   assign PSLVERR = w_err;
   assign PREADY  = 1'b1;

`ifdef SPI_LOOPBACK_EN
   logic r_loop;
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_loop <= 1'b0;
      else if (w_wr_ctrl)
         r_loop <= PWDATA[2];
   end
   assign w_loop = r_loop;
   assign w_miso = r_loop ? w_mosi : SPI_MISO;
`else
   assign w_loop = 1'b0;
   assign w_miso = SPI_MISO;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_en  <= 1'b0;
         r_div <= DWIDTH'(CLK_DIV);
      end else begin
         if (w_wr_ctrl)
            r_en <= PWDATA[0];
         if (w_wr_div)
            r_div <= PWDATA;
      end
   end

   always_ff @(posedge PCLK) begin
      if (w_push_tx)
         r_tx_mem[r_tx_wp] <= PWDATA;
      if (w_push_rx)
         r_rx_mem[w_rx_widx] <= w_rx_word;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else if (w_flush) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_push_tx)
            r_tx_wp <= f_inc(r_tx_wp);
         if (w_pop_tx)
            r_tx_rp <= f_inc(r_tx_rp);
         if (w_push_tx && !w_pop_tx)
            r_tx_cnt <= r_tx_cnt + 1'b1;
         else if (!w_push_tx && w_pop_tx)
            r_tx_cnt <= r_tx_cnt - 1'b1;
      end
   end

   // A frame finishing on the flush edge still keeps its received word.
   assign w_rx_widx = w_flush ? '0 : r_rx_wp;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else if (w_flush) begin
         r_rx_wp  <= w_push_rx ? PW'(1) : '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= w_push_rx ? N'(1) : '0;
      end else begin
         if (w_push_rx)
            r_rx_wp <= f_inc(r_rx_wp);
         if (w_pop_rx)
            r_rx_rp <= f_inc(r_rx_rp);
         if (w_push_rx && !w_pop_rx)
            r_rx_cnt <= r_rx_cnt + 1'b1;
         else if (!w_push_rx && w_pop_rx)
            r_rx_cnt <= r_rx_cnt - 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         r_state <= S_IDLE;
      else
         r_state <= w_nstate;
   end

   always_comb begin
      w_nstate  = r_state;
      w_tick    = (r_cnt == r_div_lat);
      w_pop_tx  = 1'b0;
      w_rise    = 1'b0;
      w_fall    = 1'b0;
      w_push_rx = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_en && !w_tx_empty && !w_rx_full) begin
               w_pop_tx = 1'b1;
               w_nstate = S_SETUP;
            end
         end
         S_SETUP: begin
            if (w_tick)
               w_nstate = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_tick) begin
               if (!r_sclk) begin
                  w_rise = 1'b1;
               end else begin
                  w_fall = 1'b1;
                  if (r_bits == BW'(DWIDTH)) begin
                     w_push_rx = 1'b1;
                     w_nstate  = S_HOLD;
                  end
               end
            end
         end
         S_HOLD: begin
            if (w_tick)
               w_nstate = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   assign w_rx_word = {r_shreg[DWIDTH-2:0], r_rxbit};

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_shreg   <= '0;
         r_csn     <= 1'b1;
         r_sclk    <= 1'b0;
         r_rxbit   <= 1'b0;
         r_bits    <= '0;
         r_cnt     <= '0;
         r_div_lat <= DWIDTH'(CLK_DIV);
      end else begin
         if (w_pop_tx) begin
            r_shreg   <= r_tx_mem[r_tx_rp];
            r_csn     <= 1'b0;
            r_div_lat <= r_div;
            r_cnt     <= '0;
            r_bits    <= '0;
         end else if (r_state != S_IDLE) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         end
         if (w_rise) begin
            r_sclk  <= 1'b1;
            r_rxbit <= w_miso;
            r_bits  <= r_bits + 1'b1;
         end
         if (w_fall) begin
            r_sclk  <= 1'b0;
            r_shreg <= w_rx_word;
         end
         if (w_push_rx)
            r_csn <= 1'b1;
      end
   end

   // MOSI is the live shift-register MSB, forced low while deselected.
   assign w_mosi   = r_shreg[DWIDTH-1] & ~r_csn;
   assign SPI_MOSI = w_mosi;
   assign SPI_SCLK = r_sclk;
   assign SPI_CS_N = r_csn;

endmodule

// File: tb/tb_apb_spi_master.sv
// tb_apb_spi_master: register-map vector table plus directed SPI frame,
// RX-full back-pressure, loopback and mid-frame reset sequences.
module tb_apb_spi_master;
   localparam int CLK_PER = 10;

`ifdef SPI_LOOPBACK_EN
   localparam logic [7:0] LOOP_RD = 8'h04;
   localparam logic [7:0] LB_EXP  = 8'h81;
`else
   localparam logic [7:0] LOOP_RD = 8'h00;
   localparam logic [7:0] LB_EXP  = 8'h5A;
`endif

   logic       PCLK;
   logic       PRESETn;
   logic       PSEL, PENABLE, PWRITE;
   logic [3:0] PADDR;
   logic [7:0] PWDATA, PRDATA;
   logic       PREADY, PSLVERR;
   logic       SPI_SCLK, SPI_CS_N, SPI_MOSI, SPI_MISO;

   apb_spi_master #(
      .AWIDTH(4), .DWIDTH(8), .FIFO_DEPTH(5), .CLK_DIV(2)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR),
      .SPI_SCLK(SPI_SCLK), .SPI_CS_N(SPI_CS_N),
      .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
   );

   initial PCLK = 1'b0;
   always #(CLK_PER / 2) PCLK = ~PCLK;

   int   n_tot = 0;
   int   n_pass = 0;
   int   rise_cnt = 0;
   int   frames_done = 0;
   time  t1 = 0, t2 = 0;
   logic [7:0] mosi_cap = '0;
   logic [7:0] miso_pat = '0;

   // Simple SPI slave: shifts out miso_pat MSB first, captures MOSI on rise.
   always @(posedge SPI_SCLK or negedge SPI_CS_N) begin
      if (SPI_SCLK) begin
         mosi_cap = {mosi_cap[6:0], SPI_MOSI};
         rise_cnt = rise_cnt + 1;
         if (rise_cnt == 1) t1 = $time;
         if (rise_cnt == 2) t2 = $time;
      end else begin
         rise_cnt = 0;
         mosi_cap = '0;
      end
   end

   always_comb SPI_MISO = (rise_cnt < 8) ? miso_pat[7-rise_cnt] : 1'b0;

   always @(posedge SPI_CS_N) frames_done = frames_done + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot = n_tot + 1;
      if (act === exp)
         n_pass = n_pass + 1;
      else
         $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Called at 1 time unit after a rising edge; returns likewise.
   task automatic apb(input logic w, input logic [3:0] a,
                      input logic [7:0] d, output logic [7:0] rd,
                      output logic er);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #3;
      rd = PRDATA;
      er = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      logic [7:0] rd;
      logic       er;
      apb(1'b1, a, d, rd, er);
   endtask

   task automatic wait_frames(input string nm, input int target);
      for (int i = 0; i < 3000 && frames_done < target; i++)
         @(posedge PCLK);
      #1;
      chk(nm, 32'(frames_done >= target), 32'd1);
   endtask

   typedef struct {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [7:0] rd;
      logic       er;
      int         base;

      PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0;
      PADDR = '0; PWDATA = '0;
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_csn", 32'(SPI_CS_N), 32'd1);
      chk("rst_sclk", 32'(SPI_SCLK), 32'd0);
      chk("rst_mosi", 32'(SPI_MOSI), 32'd0);
      chk("rst_prdata", 32'(PRDATA), 32'd0);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("pready", 32'(PREADY), 32'd1);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      vecs = '{
         '{0, 4'd0, 8'h00, 8'h00, 0},
         '{0, 4'd1, 8'h00, 8'h05, 0},
         '{0, 4'd4, 8'h00, 8'h02, 0},
         '{0, 4'd5, 8'h00, 8'h00, 0},
         '{0, 4'd6, 8'h00, 8'h00, 0},
         '{0, 4'd3, 8'h00, 8'h00, 1},
         '{0, 4'd6, 8'h00, 8'h00, 0},
         '{0, 4'd7, 8'h00, 8'h00, 1},
         '{0, 4'd2, 8'h00, 8'h00, 1},
         '{1, 4'd1, 8'hFF, 8'h00, 1},
         '{1, 4'd3, 8'h12, 8'h00, 1},
         '{1, 4'd6, 8'h01, 8'h00, 1},
         '{1, 4'd9, 8'h01, 8'h00, 1},
         '{1, 4'd4, 8'h07, 8'h00, 0},
         '{0, 4'd4, 8'h00, 8'h07, 0},
         '{1, 4'd5, 8'h01, 8'h00, 1},
         '{1, 4'd2, 8'h11, 8'h00, 0},
         '{1, 4'd2, 8'h22, 8'h00, 0},
         '{1, 4'd2, 8'h33, 8'h00, 0},
         '{1, 4'd2, 8'h44, 8'h00, 0},
         '{1, 4'd2, 8'h55, 8'h00, 0},
         '{1, 4'd2, 8'h66, 8'h00, 1},
         '{0, 4'd5, 8'h00, 8'h05, 0},
         '{0, 4'd1, 8'h00, 8'h06, 0},
         '{0, 4'd6, 8'h00, 8'h00, 0},
         '{1, 4'd0, 8'h04, 8'h00, 0},
         '{0, 4'd0, 8'h00, LOOP_RD, 0},
         '{1, 4'd0, 8'h08, 8'h00, 0},
         '{0, 4'd5, 8'h00, 8'h00, 0},
         '{0, 4'd1, 8'h00, 8'h05, 0},
         '{0, 4'd0, 8'h00, 8'h00, 0},
         '{0, 4'd15, 8'h00, 8'h00, 1}
      };
      foreach (vecs[i]) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
         chk($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].rdata));
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
      end

      // Single frame at fastest divider.
      wr(4'd4, 8'h00);
      wr(4'd2, 8'hA5);
      miso_pat = 8'h3C;
      base = frames_done;
      wr(4'd0, 8'h01);
      wait_frames("frame_a5_done", base + 1);
      chk("mosi_bits", 32'(mosi_cap), 32'h A5);
      chk("sclk_period", 32'(t2 - t1), 32'(2 * CLK_PER));
      repeat (2) @(posedge PCLK);
      #1;
      apb(1'b0, 4'd6, 8'h00, rd, er);
      chk("rxlvl_one", 32'(rd), 32'd1);
      apb(1'b0, 4'd3, 8'h00, rd, er);
      chk("rxdata_3c", 32'(rd), 32'h3C);
      chk("rxdata_3c_err", 32'(er), 32'd0);
      apb(1'b0, 4'd1, 8'h00, rd, er);
      chk("status_idle", 32'(rd), 32'h05);

      // RX full blocks further frames until one word is popped.
      miso_pat = 8'hC3;
      base = frames_done;
      for (int k = 0; k < 5; k++) wr(4'd2, 8'(k + 1));
      wait_frames("fill_rx_done", base + 5);
      repeat (2) @(posedge PCLK);
      #1;
      apb(1'b0, 4'd6, 8'h00, rd, er);
      chk("rxlvl_full", 32'(rd), 32'd5);
      apb(1'b0, 4'd1, 8'h00, rd, er);
      chk("status_rxfull", 32'(rd), 32'h09);
      wr(4'd2, 8'h77);
      repeat (60) @(posedge PCLK);
      #1;
      chk("no_6th_frame", 32'(frames_done), 32'(base + 5));
      chk("cs_held_high", 32'(SPI_CS_N), 32'd1);
      apb(1'b0, 4'd5, 8'h00, rd, er);
      chk("txlvl_pending", 32'(rd), 32'd1);
      apb(1'b0, 4'd3, 8'h00, rd, er);
      chk("pop_full_data", 32'(rd), 32'hC3);
      wait_frames("frame_after_pop", base + 6);
      repeat (2) @(posedge PCLK);
      #1;
      apb(1'b0, 4'd6, 8'h00, rd, er);
      chk("rxlvl_refull", 32'(rd), 32'd5);
      wr(4'd0, 8'h08);
      apb(1'b0, 4'd6, 8'h00, rd, er);
      chk("rxlvl_flushed", 32'(rd), 32'd0);

      // Loopback (LOOP ignored when the feature is not built).
      miso_pat = 8'h5A;
      base = frames_done;
      wr(4'd0, 8'h05);
      wr(4'd2, 8'h81);
      wait_frames("loop_frame", base + 1);
      repeat (2) @(posedge PCLK);
      #1;
      apb(1'b0, 4'd3, 8'h00, rd, er);
      chk("loop_rxdata", 32'(rd), 32'(LB_EXP));
      wr(4'd0, 8'h00);

      // Reset in the middle of a slow frame.
      wr(4'd4, 8'h03);
      wr(4'd2, 8'h96);
      wr(4'd2, 8'h69);
      wr(4'd0, 8'h01);
      for (int i = 0; i < 200 && SPI_CS_N; i++) @(posedge PCLK);
      #1;
      chk("midframe_cs_low", 32'(SPI_CS_N), 32'd0);
      apb(1'b0, 4'd5, 8'h00, rd, er);
      chk("midframe_txlvl", 32'(rd), 32'd1);
      repeat (10) @(posedge PCLK);
      #1;
      PRESETn = 1'b0;
      #1;
      chk("arst_csn", 32'(SPI_CS_N), 32'd1);
      chk("arst_sclk", 32'(SPI_SCLK), 32'd0);
      chk("arst_mosi", 32'(SPI_MOSI), 32'd0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      apb(1'b0, 4'd1, 8'h00, rd, er);
      chk("arst_status", 32'(rd), 32'h05);
      apb(1'b0, 4'd5, 8'h00, rd, er);
      chk("arst_txlvl", 32'(rd), 32'd0);
      apb(1'b0, 4'd4, 8'h00, rd, er);
      chk("arst_clkdiv", 32'(rd), 32'h02);
      apb(1'b0, 4'd0, 8'h00, rd, er);
      chk("arst_ctrl", 32'(rd), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
